// File: rtl/mips_register_file.sv
// mips_register_file
//   32-entry (2**ADDR_WIDTH) general-purpose register file for the five-stage
//   MIPS pipeline. Two combinational read ports (rs/rt) with same-cycle
//   write-through bypass from WB, one synchronous write port, register 0
//   hardwired to zero, register SP_INDEX resets to SP_RESET_VALUE.
//
//   Optional build macro: REGFILE_DEBUG_PORT_EN
//     Adds an unbypassed debug read port (DbgReg/DbgData) and a 32-bit
//     counter of committed writes to non-zero registers (WriteCount).
module mips_register_file #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 5,
    parameter int                    SP_INDEX       = 29,
    parameter logic [DATA_WIDTH-1:0] SP_RESET_VALUE = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_WIDTH-1:0] DbgReg,
    output logic [DATA_WIDTH-1:0] DbgData,
    output logic [31:0]           WriteCount
`endif
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int NUM_RD   = 2;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // A write to register 0 is dropped here so it never commits nor bypasses.
    logic write_en;
    assign write_en = RegWrite && (WriteReg != '0);

    // Next-state of the array: only the addressed entry takes WriteData; r0 pinned to 0.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (write_en && (WriteReg == ADDR_WIDTH'(i))) begin
                regs_d[i] = WriteData;
            end
        end
        regs_d[0] = '0;
    end

    // Register array; asynchronous reset so reads show reset contents immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= ((i == SP_INDEX) && (i != 0)) ? SP_RESET_VALUE : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    logic [ADDR_WIDTH-1:0] rd_addr [NUM_RD];
    assign rd_addr[0] = ReadReg1;
    assign rd_addr[1] = ReadReg2;

    // One read mux per port. The bypass is gated by Rst_n so that during
    // reset the ports reflect the cleared array, not the in-flight write.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [DATA_WIDTH-1:0] data_sel;

        // Array read with same-cycle WB forwarding.
        always_comb begin
            data_sel = regs_q[rd_addr[gi]];
            if (Rst_n && write_en && (WriteReg == rd_addr[gi])) begin
                data_sel = WriteData;
            end
        end
    end

    assign ReadData1 = g_rd[0].data_sel;
    assign ReadData2 = g_rd[1].data_sel;

`ifdef REGFILE_DEBUG_PORT_EN
    logic [31:0] write_count_q;
    logic [31:0] write_count_d;

    // Raw, unbypassed view of the array.
    assign DbgData    = regs_q[DbgReg];
    assign WriteCount = write_count_q;

    // Count committed non-zero-register writes; natural wrap at 2**32.
    always_comb begin
        write_count_d = write_count_q;
        if (write_en) begin
            write_count_d = write_count_q + 32'd1;
        end
    end

    // Write counter register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            write_count_q <= '0;
        end else begin
            write_count_q <= write_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// Testbench for mips_register_file: table-driven single-cycle vectors checked
// through an expected-result queue, plus hand-written sequences for the
// asynchronous reset and (when REGFILE_DEBUG_PORT_EN is defined) debug port.
module tb_mips_register_file;

    localparam int          DW   = 32;
    localparam int          AW   = 5;
    localparam logic [31:0] SPRV = 32'h7FFF_EFFC;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic [AW-1:0] ReadReg1, ReadReg2, WriteReg;
    logic [DW-1:0] WriteData;
    logic          RegWrite;
    logic [DW-1:0] ReadData1, ReadData2;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [AW-1:0] DbgReg;
    logic [DW-1:0] DbgData;
    logic [31:0]   WriteCount;
`endif

    always #5 Clk = ~Clk;

    mips_register_file #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .SP_INDEX      (29),
        .SP_RESET_VALUE(SPRV)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .RegWrite (RegWrite),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
`ifdef REGFILE_DEBUG_PORT_EN
        ,
        .DbgReg    (DbgReg),
        .DbgData   (DbgData),
        .WriteCount(WriteCount)
`endif
    );

    typedef struct {
        logic [AW-1:0] rr1;
        logic [AW-1:0] rr2;
        logic          we;
        logic [AW-1:0] wr;
        logic [DW-1:0] wd;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;

    typedef struct {
        int            idx;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive one vector after a rising edge, queue its expectation, compare
    // the pre-edge (bypassed) outputs at the falling edge.
    task automatic run_vec(input int idx);
        exp_t e;
        @(posedge Clk);
        #1;
        ReadReg1  = vecs[idx].rr1;
        ReadReg2  = vecs[idx].rr2;
        RegWrite  = vecs[idx].we;
        WriteReg  = vecs[idx].wr;
        WriteData = vecs[idx].wd;
        sb.push_back('{idx, vecs[idx].e1, vecs[idx].e2});
        @(negedge Clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty vec=%0d", idx);
        end else begin
            e = sb.pop_front();
            $display("txn vec=%0d rr1=%0d rr2=%0d we=%0b wr=%0d wd=%h rd1=%h rd2=%h",
                     e.idx, ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData, ReadData1, ReadData2);
            check($sformatf("vec%0d_rd1", e.idx), ReadData1, e.e1);
            check($sformatf("vec%0d_rd2", e.idx), ReadData2, e.e2);
        end
    endtask

    initial begin
        //            rr1 rr2 we  wr  wd              e1              e2
        vecs[0]  = '{5'd5,  5'd29, 1'b0, 5'd0,  32'h0,         32'h0,         SPRV};
        vecs[1]  = '{5'd8,  5'd0,  1'b1, 5'd8,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0};
        vecs[2]  = '{5'd8,  5'd8,  1'b0, 5'd3,  32'h0000FFFF,  32'hDEADBEEF,  32'hDEADBEEF};
        vecs[3]  = '{5'd3,  5'd0,  1'b1, 5'd0,  32'h00001234,  32'h0,         32'h0};
        vecs[4]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0};
        vecs[5]  = '{5'd9,  5'd9,  1'b1, 5'd9,  32'hA5A5A5A5,  32'hA5A5A5A5,  32'hA5A5A5A5};
        vecs[6]  = '{5'd9,  5'd8,  1'b0, 5'd0,  32'h0,         32'hA5A5A5A5,  32'hDEADBEEF};
        vecs[7]  = '{5'd10, 5'd0,  1'b1, 5'd10, 32'h00000011,  32'h00000011,  32'h0};
        vecs[8]  = '{5'd10, 5'd10, 1'b0, 5'd10, 32'h000000FF,  32'h00000011,  32'h00000011};
        vecs[9]  = '{5'd10, 5'd8,  1'b0, 5'd0,  32'h0,         32'h00000011,  32'hDEADBEEF};
        vecs[10] = '{5'd29, 5'd31, 1'b1, 5'd31, 32'hCAFEF00D,  SPRV,          32'hCAFEF00D};
        vecs[11] = '{5'd31, 5'd29, 1'b1, 5'd29, 32'h12345678,  32'hCAFEF00D,  32'h12345678};
        vecs[12] = '{5'd29, 5'd3,  1'b0, 5'd0,  32'h0,         32'h12345678,  32'h0};
        vecs[13] = '{5'd8,  5'd9,  1'b1, 5'd8,  32'h0,         32'h0,         32'hA5A5A5A5};
        vecs[14] = '{5'd8,  5'd1,  1'b0, 5'd0,  32'h0,         32'h0,         32'h0};

        Rst_n     = 1'b0;
        ReadReg1  = 5'd5;
        ReadReg2  = 5'd29;
        WriteReg  = 5'd0;
        WriteData = '0;
        RegWrite  = 1'b0;
`ifdef REGFILE_DEBUG_PORT_EN
        DbgReg    = 5'd0;
`endif
        #12;
        check("reset_rd1_r5", ReadData1, 32'h0);
        check("reset_rd2_sp", ReadData2, SPRV);
        @(negedge Clk);
        Rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(i);
        end

        // Asynchronous reset mid-cycle with a write in flight.
        @(posedge Clk);
        #1;
        ReadReg1  = 5'd9;
        ReadReg2  = 5'd29;
        RegWrite  = 1'b1;
        WriteReg  = 5'd5;
        WriteData = 32'h00000055;
        #1;
        check("pre_areset_r9", ReadData1, 32'hA5A5A5A5);
        check("pre_areset_sp", ReadData2, 32'h12345678);
        Rst_n = 1'b0;
        #1;
        check("areset_r9", ReadData1, 32'h0);
        check("areset_sp", ReadData2, SPRV);
        ReadReg1 = 5'd5;
        #1;
        check("areset_no_bypass", ReadData1, 32'h0);
        @(posedge Clk);
        #1;
        check("areset_write_lost_edge", ReadData1, 32'h0);
        @(negedge Clk);
        Rst_n    = 1'b1;
        RegWrite = 1'b0;
        ReadReg2 = 5'd9;
        #1;
        $display("txn areset_release rd1=%h rd2=%h", ReadData1, ReadData2);
        check("post_reset_r5", ReadData1, 32'h0);
        check("post_reset_r9", ReadData2, 32'h0);

`ifdef REGFILE_DEBUG_PORT_EN
        check("dbg_count_reset", WriteCount, 32'h0);
        @(posedge Clk); #1;
        RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'h00000111;
        @(posedge Clk); #1;
        WriteReg = 5'd0; WriteData = 32'h00000222;
        @(posedge Clk); #1;
        WriteReg = 5'd2; WriteData = 32'h00000333;
        @(posedge Clk); #1;
        WriteReg = 5'd1; WriteData = 32'h00000999; DbgReg = 5'd1;
        #1;
        check("dbg_unbypassed_r1", DbgData, 32'h00000111);
        RegWrite = 1'b0; DbgReg = 5'd2;
        #1;
        $display("txn dbg count=%h dbg=%h", WriteCount, DbgData);
        check("dbg_count_3w", WriteCount, 32'd2);
        check("dbg_data_r2", DbgData, 32'h00000333);
        Rst_n = 1'b0;
        #1;
        check("dbg_count_areset", WriteCount, 32'h0);
        check("dbg_data_areset", DbgData, 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
